// File: rtl/dmem_bank_if.sv
// Request/response bus of the emulator data memory.
// The core drives the master side; dmem_bank sits on the slave side.
interface dmem_bank_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [2:0]            req_rwtyp;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_rwtyp, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_rwtyp, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_bank.sv
// Byte-addressed data memory with lane writes, load extension and fixed-latency in-order responses.
// Optional macro DMEM_BOUNDS_CHECK_EN flags addresses beyond the array instead of aliasing them.
module dmem_bank #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_LOG2 = 14,
   parameter int RD_LATENCY = 1
) (
   input logic        clk,
   input logic        rstn,
   dmem_bank_if.slave bus
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int LB    = $clog2(NB);
   localparam int WORDS = 1 << DEPTH_LOG2;

   logic                  r_ready;
   logic [DATA_WIDTH-1:0] r_mem [WORDS];
   logic                  r_pv [RD_LATENCY];
   logic                  r_pe [RD_LATENCY];
   logic [DATA_WIDTH-1:0] r_pd [RD_LATENCY];

   logic                  w_acc;
   logic                  w_err;
   logic                  w_misal;
   logic                  w_illegal;
   logic                  w_oob;
   logic                  w_hi_nz;
   logic                  w_sbit;
   logic [1:0]            w_size;
   logic [3:0]            w_nbytes;
   logic [LB-1:0]         w_off;
   logic [LB+2:0]         w_shamt;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [NB-1:0]         w_be;
   logic [DATA_WIDTH-1:0] w_wdata_sh;
   logic [DATA_WIDTH-1:0] w_rd_sh;
   logic [DATA_WIDTH-1:0] w_mask;
   logic [DATA_WIDTH-1:0] w_ext;
   logic [DATA_WIDTH-1:0] w_rdata;

   assign w_acc     = bus.req_valid & r_ready;
   assign w_size    = bus.req_rwtyp[1:0];
   assign w_off     = bus.req_addr[LB-1:0];
   assign w_idx     = bus.req_addr[DEPTH_LOG2+LB-1:LB];
   assign w_nbytes  = 4'd1 << w_size;
   assign w_shamt   = {w_off, 3'b000};
   assign w_misal   = (w_off & LB'(w_nbytes - 4'd1)) != '0;
   assign w_illegal = (w_size == 2'd3) && (DATA_WIDTH == 32);
   assign w_hi_nz   = |(bus.req_addr >> (DEPTH_LOG2 + LB));

`ifdef DMEM_BOUNDS_CHECK_EN
   assign w_oob = w_hi_nz;
`else
   // Upper address bits alias onto the array.
   logic w_unused_hi;
   assign w_unused_hi = w_hi_nz;
   assign w_oob       = 1'b0;
`endif

   assign w_err = w_misal | w_illegal | w_oob;

   always_comb begin
      w_be   = '0;
      w_mask = '0;
      for (int i = 0; i < NB; i++) begin
         w_be[i]          = (i >= int'(w_off)) && (i < int'(w_off) + int'(w_nbytes));
         w_mask[i*8 +: 8] = (i < int'(w_nbytes)) ? 8'hFF : 8'h00;
      end
   end

   assign w_wdata_sh = bus.req_wdata << w_shamt;
   assign w_rd_sh    = r_mem[w_idx] >> w_shamt;

   always_comb begin
      w_sbit = 1'b0;
      case (w_size)
         2'd0:    w_sbit = w_rd_sh[7];
         2'd1:    w_sbit = w_rd_sh[15];
         2'd2:    w_sbit = w_rd_sh[31];
         default: w_sbit = w_rd_sh[DATA_WIDTH-1];
      endcase
   end

   // A full-width mask leaves ~w_mask empty, so full-width loads ignore the unsigned bit.
   assign w_ext   = (w_rd_sh & w_mask) | ((w_sbit & ~bus.req_rwtyp[2]) ? ~w_mask : '0);
   assign w_rdata = (w_err | bus.req_we) ? '0 : w_ext;

   always_ff @(posedge clk) begin
      if (w_acc && bus.req_we && !w_err) begin
         for (int i = 0; i < NB; i++) begin
            if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wdata_sh[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_ready <= 1'b0;
      else       r_ready <= 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < RD_LATENCY; s++) begin
            r_pv[s] <= 1'b0;
            r_pe[s] <= 1'b0;
            r_pd[s] <= '0;
         end
      end else begin
         r_pv[0] <= w_acc;
         r_pe[0] <= w_acc & w_err;
         r_pd[0] <= w_acc ? w_rdata : '0;
         for (int s = 1; s < RD_LATENCY; s++) begin
            r_pv[s] <= r_pv[s-1];
            r_pe[s] <= r_pe[s-1];
            r_pd[s] <= r_pd[s-1];
         end
      end
   end

   assign bus.req_ready = r_ready;
   assign bus.rsp_valid = r_pv[RD_LATENCY-1];
   assign bus.rsp_err   = r_pe[RD_LATENCY-1];
   assign bus.rsp_rdata = r_pd[RD_LATENCY-1];
endmodule

// File: tb/tb_dmem_bank.sv
// Bench for dmem_bank: two instances (latency 3 and 1, 16-word array) fed identical requests,
// a byte-array model producing expected responses and queues matching them in order.
module tb_dmem_bank;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int DL = 4;

   typedef struct {
      logic        err;
      logic [31:0] rd;
      int          acc;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   dmem_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();
   dmem_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

   dmem_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .RD_LATENCY(3))
      u_dut3 (.clk(clk), .rstn(rstn), .bus(bus3));
   dmem_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .RD_LATENCY(1))
      u_dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

   exp_t        q3[$];
   exp_t        q1[$];
   logic [7:0]  m_mem [64];
   int          cyc     = 0;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          rv3     = 0;
   int          rv1     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                        input logic [31:0] wd, output logic err, output logic [31:0] rd);
      int          nb;
      logic [31:0] v;
      nb  = 1 << typ[1:0];
      err = (typ[1:0] == 2'd3) || ((addr % nb) != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
      if (addr >= 64) err = 1'b1;
`endif
      rd = '0;
      if (!err) begin
         if (we) begin
            for (int k = 0; k < nb; k++) m_mem[(addr + k) % 64] = wd[8*k +: 8];
         end else begin
            v = '0;
            for (int k = 0; k < nb; k++) v[8*k +: 8] = m_mem[(addr + k) % 64];
            if (!typ[2] && nb < 4 && v[8*nb-1]) begin
               for (int j = 8*nb; j < 32; j++) v[j] = 1'b1;
            end
            rd = v;
         end
      end
   endtask

   task automatic issue(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                        input logic [31:0] wd);
      exp_t e;
      model(we, typ, addr, wd, e.err, e.rd);
      e.acc = cyc + 1;
      bus3.req_valid = 1'b1; bus3.req_we = we; bus3.req_rwtyp = typ;
      bus3.req_addr  = addr; bus3.req_wdata = wd;
      bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_rwtyp = typ;
      bus1.req_addr  = addr; bus1.req_wdata = wd;
      q3.push_back(e);
      q1.push_back(e);
      @(posedge clk);
      #1;
      bus3.req_valid = 1'b0;
      bus1.req_valid = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      q3.delete();
      q1.delete();
      rv3 = 0;
      rv1 = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_ready3", bus3.req_ready, 0);
         chk("rst_ready1", bus1.req_ready, 0);
         chk("rst_valid3", bus3.rsp_valid, 0);
         chk("rst_valid1", bus1.rsp_valid, 0);
      end
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("ready_pre_edge3", bus3.req_ready, 0);
      chk("ready_pre_edge1", bus1.req_ready, 0);
      @(posedge clk);
      #1;
      chk("ready_post_edge3", bus3.req_ready, 1);
      chk("ready_post_edge1", bus1.req_ready, 1);
   endtask

   // Latency-N response is loaded on edge acc+N-1 and is seen at the following negedge.
   initial begin : mon3
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (bus3.rsp_valid) begin
               rv3++;
               chk("rsp_expected3", q3.size() != 0, 1);
               if (q3.size() != 0) begin
                  e = q3.pop_front();
                  chk("rdata3", bus3.rsp_rdata, e.rd);
                  chk("err3", bus3.rsp_err, e.err);
                  chk("latency3", cyc, e.acc + 2);
               end
            end else begin
               chk("idle3", {bus3.rsp_err, bus3.rsp_rdata}, 0);
            end
         end
      end
   end

   initial begin : mon1
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (bus1.rsp_valid) begin
               rv1++;
               chk("rsp_expected1", q1.size() != 0, 1);
               if (q1.size() != 0) begin
                  e = q1.pop_front();
                  chk("rdata1", bus1.rsp_rdata, e.rd);
                  chk("err1", bus1.rsp_err, e.err);
                  chk("latency1", cyc, e.acc);
               end
            end else begin
               chk("idle1", {bus1.rsp_err, bus1.rsp_rdata}, 0);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_rwtyp = '0;
      bus3.req_addr  = '0;   bus3.req_wdata = '0;
      bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_rwtyp = '0;
      bus1.req_addr  = '0;   bus1.req_wdata = '0;
      do_reset();

      // lane write then immediate read-back of the same word
      issue(1'b1, 3'b010, 32'h10, 32'h1122_3344);
      issue(1'b1, 3'b000, 32'h12, 32'h0000_00AA);
      issue(1'b0, 3'b010, 32'h10, 32'h0);

      // sign / zero extension
      issue(1'b1, 3'b001, 32'h24, 32'h0000_8001);
      issue(1'b0, 3'b001, 32'h24, 32'h0);
      issue(1'b0, 3'b101, 32'h24, 32'h0);
      issue(1'b0, 3'b000, 32'h25, 32'h0);
      issue(1'b0, 3'b100, 32'h24, 32'h0);
      issue(1'b0, 3'b001, 32'h12, 32'h0);

      // misalignment and illegal size; store must not land
      issue(1'b0, 3'b010, 32'h11, 32'h0);
      issue(1'b1, 3'b001, 32'h13, 32'h0000_BEEF);
      issue(1'b0, 3'b010, 32'h10, 32'h0);
      issue(1'b0, 3'b011, 32'h10, 32'h0);
      issue(1'b1, 3'b010, 32'h16, 32'hDEAD_BEEF);
      issue(1'b0, 3'b010, 32'h14, 32'h0);

      // back-to-back throughput
      issue(1'b1, 3'b010, 32'h00, 32'hA000_0001);
      issue(1'b1, 3'b010, 32'h04, 32'hB000_0002);
      issue(1'b1, 3'b010, 32'h08, 32'hC000_0003);
      issue(1'b1, 3'b010, 32'h0C, 32'hD000_0004);
      issue(1'b0, 3'b010, 32'h00, 32'h0);
      issue(1'b0, 3'b010, 32'h04, 32'h0);
      issue(1'b0, 3'b010, 32'h08, 32'h0);
      issue(1'b0, 3'b010, 32'h0C, 32'h0);
      repeat (4) @(posedge clk);
      #1;

      // upper address bits: alias or bounds error
      issue(1'b0, 3'b010, 32'h40, 32'h0);
      issue(1'b1, 3'b010, 32'h44, 32'h5A5A_1234);
      issue(1'b0, 3'b010, 32'h04, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      chk("drain_a3", q3.size(), 0);
      chk("drain_a1", q1.size(), 0);

      // store on the last edge before reset is kept
      issue(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D);
      do_reset();
      issue(1'b0, 3'b010, 32'h30, 32'h0);
      repeat (4) @(posedge clk);
      #1;

      // in-flight loads are dropped by reset
      issue(1'b0, 3'b010, 32'h00, 32'h0);
      issue(1'b0, 3'b010, 32'h04, 32'h0);
      do_reset();
      repeat (6) @(posedge clk);
      #1;
      chk("no_rsp_after_reset3", rv3, 0);
      chk("no_rsp_after_reset1", rv1, 0);

      issue(1'b0, 3'b010, 32'h08, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      chk("drain_b3", q3.size(), 0);
      chk("drain_b1", q1.size(), 0);
      chk("post_reset_rsp3", rv3, 1);
      chk("post_reset_rsp1", rv1, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_bank.md
Name: dmem_bank

Overview:
- Parametrised, byte-addressed data memory for the RV32/RV64 emulation core; successor to the fixed 64K-word emulator RAM.
- Accepts one load/store per cycle over a valid/ready request port.
- Returns in-order responses after a configurable read latency.
- Performs true per-lane byte writes, sign/zero extension on loads, and misalignment detection.

Parameters:
- ADDR_WIDTH, 32: request byte-address width.
- DATA_WIDTH, 32: word width; legal values 32 or 64.
- DEPTH_LOG2, 14: log2 of number of words in the array.
- RD_LATENCY, 1: cycles from request acceptance to rsp_valid; legal 1..4; applies to reads and writes.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_rwtyp  in  3  [1:0] size (0 byte, 1 half, 2 word, 3 dword when DATA_WIDTH=64); [2] unsigned load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (low bits).
- rsp_valid  out  1  response present; consumer cannot stall.
- rsp_rdata  out  DATA_WIDTH  load result, extended to full width; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or had an illegal size.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on clk/rstn.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. All pipeline valid bits cleared. Array contents are not reset.
- req_ready is registered. It goes to 1 on the first rising clk edge after rstn deasserts and then stays 1; there is no back-pressure source.
- Acceptance: a request is accepted on a rising edge where req_valid and req_ready are both 1.
- Word index: req_addr[DEPTH_LOG2+LB-1:LB], where LB = log2(DATA_WIDTH/8). Lane offset: req_addr[LB-1:0].
- Alignment: the request is misaligned if addr mod size-bytes != 0. Size 3 with DATA_WIDTH=32 is illegal. Either case sets rsp_err=1 and rsp_rdata=0, and a store does not modify the array.
- Store: written at the acceptance edge. Only lanes covered by size at the lane offset are updated, all other bytes are preserved. Source bytes come from req_wdata low bytes, shifted to the lane.
- Load: array read at the acceptance edge. The selected bytes are shifted down. If rwtyp[2]=0 the result is sign-extended from the top selected bit, otherwise zero-extended. A full-width load ignores rwtyp[2].
- Ordering: a load accepted the cycle after a store to the same word returns the new data. Back-to-back requests are allowed every cycle.
- Response timing: the response for the request accepted at edge N appears at edge N+RD_LATENCY-1+1, i.e. RD_LATENCY edges later. Responses stay in order.
  - rsp_valid is high for exactly one cycle per accepted request.
  - When no response is due, rsp_valid=0 and rsp_rdata=0.
- Pipeline: RD_LATENCY-1 registered stages carry {valid, err, rdata} after the array read stage.
- Address upper bits: bits above DEPTH_LOG2+LB are ignored (aliasing) unless the optional feature is compiled in.
- Reset mid-operation: in-flight responses are discarded, and no rsp_valid appears for them. A store accepted on the last edge before reset assertion is committed.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: any request with a nonzero req_addr bit above DEPTH_LOG2+LB-1 gets rsp_err=1 and rsp_rdata=0. Stores to such addresses are suppressed.
- Undefined: the upper bits are ignored and the address wraps modulo the array size, with no error.

Test Plan:
- Reset release: hold rstn=0 three cycles, then release -> req_ready=0 until the first edge, then 1. rsp_valid stays 0 throughout.
- Lane write, DATA_WIDTH=32: SW 0x11223344 @0x100, then SB 0xAA @0x102, then LW @0x100 -> rdata 0x11AA3344, rsp_err=0.
- Sign/zero extension: SH 0x8001 @0x204, then LH @0x204 -> 0xFFFF8001; then LHU @0x204 -> 0x00008001.
- Misalignment: LW @0x101 -> rsp_err=1, rdata 0. SH 0xBEEF @0x103, then LW @0x100 -> unchanged contents.
- Latency and throughput, RD_LATENCY=3: four back-to-back loads at edges 0..3 -> rsp_valid at edges 3..6 with data in issue order. Repeat with RD_LATENCY=1, responses at edges 1..4.
- Bounds and reset, DEPTH_LOG2=4: LW @0x40, or the macro-on case -> rsp_err=1 with the macro, data of @0x0 without it. Assert rstn with two loads in flight -> no rsp_valid for them after release.
